// File: rtl/stage_two_cordic.sv
// Iterative rotation-mode CORDIC: cosine of a Q2.20 angle, one micro-rotation
// per enabled cycle, with the first stage's float operands carried alongside.
module stage_two_cordic #(
  parameter int                     ITERATIONS     = 20,
  parameter int                     ANGLE_WIDTH    = 22,
  parameter int                     INT_WIDTH      = 24,
  parameter int                     FLT_DATA_WIDTH = 32,
  parameter logic [ANGLE_WIDTH-1:0] CORDIC_GAIN    = 22'd636750
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      start,
  input  logic [ANGLE_WIDTH-1:0]    angle,
  input  logic [FLT_DATA_WIDTH-1:0] half_in,
  input  logic [FLT_DATA_WIDTH-1:0] square_in,
  output logic [ANGLE_WIDTH-1:0]    cos_out,
  output logic [FLT_DATA_WIDTH-1:0] half_out,
  output logic [FLT_DATA_WIDTH-1:0] square_out,
  output logic                      busy,
  output logic                      done
);

  localparam int IW = $clog2(ITERATIONS);
  localparam int GW = INT_WIDTH - ANGLE_WIDTH;
  localparam logic signed [INT_WIDTH-1:0] SAT_MAX = INT_WIDTH'((1 <<< (ANGLE_WIDTH-1)) - 1);
  localparam logic signed [INT_WIDTH-1:0] SAT_MIN = INT_WIDTH'(-(1 <<< (ANGLE_WIDTH-1)));
  localparam logic [IW-1:0] LAST_ITER = IW'(ITERATIONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_DONE} state_t;

  // round(atan(2^-i) * 2^20)
  function automatic logic signed [INT_WIDTH-1:0] atan_lut(input logic [IW-1:0] idx);
    logic signed [INT_WIDTH-1:0] v;
    case (idx)
      5'd0:  v = INT_WIDTH'(823550);
      5'd1:  v = INT_WIDTH'(486170);
      5'd2:  v = INT_WIDTH'(256879);
      5'd3:  v = INT_WIDTH'(130396);
      5'd4:  v = INT_WIDTH'(65451);
      5'd5:  v = INT_WIDTH'(32757);
      5'd6:  v = INT_WIDTH'(16383);
      5'd7:  v = INT_WIDTH'(8192);
      5'd8:  v = INT_WIDTH'(4096);
      5'd9:  v = INT_WIDTH'(2048);
      5'd10: v = INT_WIDTH'(1024);
      5'd11: v = INT_WIDTH'(512);
      5'd12: v = INT_WIDTH'(256);
      5'd13: v = INT_WIDTH'(128);
      5'd14: v = INT_WIDTH'(64);
      5'd15: v = INT_WIDTH'(32);
      5'd16: v = INT_WIDTH'(16);
      5'd17: v = INT_WIDTH'(8);
      5'd18: v = INT_WIDTH'(4);
      5'd19: v = INT_WIDTH'(2);
      default: v = '0;
    endcase
    return v;
  endfunction

  state_t                      state_q, state_d;
  logic                        start_q, start_d;
  logic signed [INT_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [IW-1:0]               i_q, i_d;
  logic [ANGLE_WIDTH-1:0]      cos_q, cos_d;
  logic [FLT_DATA_WIDTH-1:0]   half_q, half_d, square_q, square_d;
  logic                        done_q, done_d, busy_q, busy_d;

  logic                        start_ev;
  logic signed [INT_WIDTH-1:0] x_sh, y_sh, atan_i, x_sat;

  assign start_ev = start & ~start_q;
  assign x_sh     = x_q >>> i_q;
  assign y_sh     = y_q >>> i_q;
  assign atan_i   = atan_lut(i_q);

  always_comb begin
    x_sat = x_q;
    if (x_q > SAT_MAX)      x_sat = SAT_MAX;
    else if (x_q < SAT_MIN) x_sat = SAT_MIN;
  end

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    i_d      = i_q;
    cos_d    = cos_q;
    half_d   = half_q;
    square_d = square_q;
    done_d   = done_q;
    if (clk_en) begin
      start_d = start;
      done_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ev) begin
            x_d      = {{GW{1'b0}}, CORDIC_GAIN};
            y_d      = '0;
            z_d      = {{GW{angle[ANGLE_WIDTH-1]}}, angle};
            i_d      = '0;
            half_d   = half_in;
            square_d = square_in;
            state_d  = S_ROTATE;
          end
        end
        S_ROTATE: begin
          // direction from the sign of the residual angle; all terms use old x/y/z
          if (!z_q[INT_WIDTH-1]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_i;
          end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_i;
          end
          i_d = i_q + 1'b1;
          if (i_q == LAST_ITER) state_d = S_DONE;
        end
        S_DONE: begin
          cos_d   = x_sat[ANGLE_WIDTH-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // busy stays up through the done pulse even though the FSM is back in IDLE
    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      i_q      <= '0;
      cos_q    <= '0;
      half_q   <= '0;
      square_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      i_q      <= i_d;
      cos_q    <= cos_d;
      half_q   <= half_d;
      square_q <= square_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign cos_out    = cos_q;
  assign half_out   = half_q;
  assign square_out = square_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_stage_two_cordic.sv
// Scoreboard bench for stage_two_cordic: reference cosine from $cos, latency,
// held/ignored starts, clk_en stalls and mid-operation reset.
module tb_stage_two_cordic;

  logic        clk = 1'b0;
  logic        rst, clk_en, start;
  logic [21:0] angle;
  logic [31:0] half_in, square_in;
  logic [21:0] cos_out;
  logic [31:0] half_out, square_out;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;

  typedef struct {
    longint      c;
    logic [31:0] h;
    logic [31:0] s;
  } exp_t;
  exp_t sb[$];

  stage_two_cordic dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .angle(angle),
    .half_in(half_in), .square_in(square_in), .cos_out(cos_out),
    .half_out(half_out), .square_out(square_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp, input longint tol = 0);
    longint diff;
    checks++;
    diff = (got > exp) ? got - exp : exp - got;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic longint cos_ref(input int a);
    return longint'($rtoi($floor($cos(real'(a) / 1048576.0) * 1048576.0 + 0.5)));
  endfunction

  // results are compared on the rising edge of done only, so a stretched pulse pops once
  always @(negedge clk) begin
    if (done && !done_prev) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("cos", longint'($signed(cos_out)), e.c, 8);
        chk("half", longint'(half_out), longint'(e.h));
        chk("square", longint'(square_out), longint'(e.s));
      end
    end
    done_prev <= done;
  end

  task automatic send_start(input int a, input logic [31:0] h, input logic [31:0] s,
                            input bit push, input longint exp_c);
    exp_t e;
    @(negedge clk);
    angle = 22'(a); half_in = h; square_in = s; start = 1'b1;
    if (push) begin
      e.c = exp_c; e.h = h; e.s = s;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_e0", busy, 1);
  endtask

  // counts edges after the one the caller already consumed; optional clk_en stall
  // mid-flight and optional stretch of the done pulse
  task automatic wait_done(input string tag, input int exp_n, input int st_from,
                           input int st_len, input int stretch);
    int n = 0;
    bit seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (st_len > 0 && n == st_from) clk_en = 1'b0;
      if (st_len > 0 && n == st_from + st_len) clk_en = 1'b1;
      if (done) seen = 1;
    end
    chk({tag, "_lat"}, n, exp_n);
    if (seen) begin
      if (stretch > 0) begin
        clk_en = 1'b0;
        for (int k = 0; k < stretch; k++) begin
          @(posedge clk); @(negedge clk);
          chk({tag, "_stretch"}, done, 1);
        end
        clk_en = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      chk({tag, "_done_drop"}, done, 0);
      chk({tag, "_busy_drop"}, busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int dc0, a;
    rst = 1'b1; clk_en = 1'b1; start = 1'b0;
    angle = '0; half_in = '0; square_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_cos", cos_out, 0);
    chk("rst_half", half_out, 0);
    chk("rst_square", square_out, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // zero angle
    send_start(0, 32'h3F00_0000, 32'h4080_0000, 1, 1048576);
    wait_done("zero", 21, 0, 0, 0);

    // extremes
    send_start(1048576, 32'h3F80_0000, 32'h4000_0000, 1, 566548);
    wait_done("one_rad", 21, 0, 0, 0);
    send_start(-524288, 32'hBF00_0000, 32'h3E80_0000, 1, 920209);
    wait_done("neg_half", 21, 0, 0, 0);
    send_start(-1048576, 32'h1234_5678, 32'h9ABC_DEF0, 1, 566548);
    wait_done("neg_one", 21, 0, 0, 0);

    // random angles
    for (int r = 0; r < 4; r++) begin
      a = int'($urandom_range(0, 2097152)) - 1048576;
      send_start(a, $urandom, $urandom, 1, cos_ref(a));
      wait_done("rand", 21, 0, 0, 0);
    end

    // held start: single operation, then re-arm after a low cycle
    dc0 = done_cnt;
    @(negedge clk);
    angle = 22'(300000); half_in = 32'h1111_1111; square_in = 32'h2222_2222; start = 1'b1;
    sb.push_back('{cos_ref(300000), 32'h1111_1111, 32'h2222_2222});
    repeat (40) @(negedge clk);
    chk("held_once", done_cnt - dc0, 1);
    start = 1'b0;
    @(negedge clk);
    angle = 22'(-700000); half_in = 32'h3333_3333; square_in = 32'h4444_4444; start = 1'b1;
    sb.push_back('{cos_ref(-700000), 32'h3333_3333, 32'h4444_4444});
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    wait_done("rearm", 21, 0, 0, 0);
    chk("held_total", done_cnt - dc0, 2);

    // start while busy is ignored
    dc0 = done_cnt;
    send_start(200000, 32'hAAAA_0001, 32'hBBBB_0001, 1, cos_ref(200000));
    repeat (9) @(negedge clk);
    angle = 22'(-900000); half_in = 32'hDEAD_BEEF; square_in = 32'hFEED_FACE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rej_half", half_out, 32'hAAAA_0001);
    wait_done("busy_rej", 11, 0, 0, 0);
    repeat (30) @(negedge clk);
    chk("busy_rej_cnt", done_cnt - dc0, 1);

    // clk_en stall mid-rotate, then stretched done
    send_start(777777, 32'h5555_0000, 32'h6666_0000, 1, cos_ref(777777));
    wait_done("stall", 26, 5, 5, 3);

    // reset mid-operation
    dc0 = done_cnt;
    send_start(400000, 32'h7777_0000, 32'h8888_0000, 0, 0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cos", cos_out, 0);
    chk("mid_rst_half", half_out, 0);
    chk("mid_rst_square", square_out, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_rst_nodone", done_cnt - dc0, 0);
    send_start(-100000, 32'h9999_0000, 32'hCCCC_0000, 1, cos_ref(-100000));
    wait_done("after_rst", 21, 0, 0, 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
